// File: rtl/ula_result_fifo_if.sv
// rtl/ula_result_fifo_if.sv - push/pop handshake bundle for the ULA result FIFO
interface ula_result_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_v;
  logic        in_c;
  logic        in_n;
  logic        in_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [AW:0] count;
  logic        sticky_clr;
  logic        sticky_v;
  logic        sticky_c;

  modport master (
    output in_valid, in_result, in_v, in_c, in_n, in_z, out_ready, sticky_clr,
    input  in_ready, out_valid, out_result, out_flags, count, sticky_v, sticky_c
  );

  modport slave (
    input  in_valid, in_result, in_v, in_c, in_n, in_z, out_ready, sticky_clr,
    output in_ready, out_valid, out_result, out_flags, count, sticky_v, sticky_c
  );
endinterface

// File: rtl/ula_result_fifo.sv
// rtl/ula_result_fifo.sv - result/flag FIFO behind the 32-bit ULA; sticky v/c accumulator under ULA_STICKY_FLAGS_EN
module ula_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  ula_result_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [35:0]   mem_q [DEPTH];
  logic [35:0]   mem_d [DEPTH];
  logic          push;
  logic          pop;

  // Ready depends only on occupancy, so a pop never opens a slot in the same cycle.
  assign bus.in_ready  = (count_q < (AW+1)'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.out_result = mem_q[rd_ptr_q][35:4];
  assign bus.out_flags  = mem_q[rd_ptr_q][3:0];
  assign bus.count      = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_result, bus.in_v, bus.in_c, bus.in_n, bus.in_z};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef ULA_STICKY_FLAGS_EN
  logic sticky_v_q, sticky_v_d;
  logic sticky_c_q, sticky_c_d;

  always_comb begin
    sticky_v_d = sticky_v_q;
    sticky_c_d = sticky_c_q;
    if (bus.sticky_clr) begin
      sticky_v_d = push && bus.in_v;
      sticky_c_d = push && bus.in_c;
    end else if (push) begin
      sticky_v_d = sticky_v_q | bus.in_v;
      sticky_c_d = sticky_c_q | bus.in_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_v_q <= 1'b0;
      sticky_c_q <= 1'b0;
    end else begin
      sticky_v_q <= sticky_v_d;
      sticky_c_q <= sticky_c_d;
    end
  end

  assign bus.sticky_v = sticky_v_q;
  assign bus.sticky_c = sticky_c_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = bus.sticky_clr;
  assign bus.sticky_v      = 1'b0;
  assign bus.sticky_c      = 1'b0;
`endif
endmodule

// File: tb/tb_ula_result_fifo.sv
// tb/tb_ula_result_fifo.sv - scoreboard bench for ula_result_fifo with queue reference model
module tb_ula_result_fifo;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ula_result_fifo_if #(.DEPTH(DEPTH)) bus ();

  ula_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered queue of {result, flags} plus an occupancy counter.
  logic [35:0] exp_q[$];
  int          model_cnt;
  logic        model_sv;
  logic        model_sc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic push_acc;
    logic pop_acc;
    if (rst) begin
      exp_q.delete();
      model_cnt <= 0;
      model_sv  <= 1'b0;
      model_sc  <= 1'b0;
    end else begin
      push_acc = bus.in_valid && (model_cnt < DEPTH);
      pop_acc  = bus.out_ready && (model_cnt != 0);
      if (push_acc)
        exp_q.push_back({bus.in_result, bus.in_v, bus.in_c, bus.in_n, bus.in_z});
      model_cnt <= model_cnt + (push_acc ? 1 : 0) - (pop_acc ? 1 : 0);
`ifdef ULA_STICKY_FLAGS_EN
      if (bus.sticky_clr) begin
        model_sv <= push_acc && bus.in_v;
        model_sc <= push_acc && bus.in_c;
      end else if (push_acc) begin
        model_sv <= model_sv | bus.in_v;
        model_sc <= model_sc | bus.in_c;
      end
`endif
    end
  end

  // Monitor: samples on the falling edge; a visible valid&ready beat will pop at the next rise.
  logic        held;
  logic [35:0] held_data;

  always @(negedge clk) begin
    logic [35:0] exp_word;
    if (rst) begin
      held = 1'b0;
    end else begin
      chk("count", 64'(bus.count), 64'(model_cnt));
      chk("out_valid", 64'(bus.out_valid), 64'(model_cnt != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(model_cnt < DEPTH));
      chk("sticky_v", 64'(bus.sticky_v), 64'(model_sv));
      chk("sticky_c", 64'(bus.sticky_c), 64'(model_sc));
      if (held && bus.out_valid)
        chk("stall_stable", 64'({bus.out_result, bus.out_flags}), 64'(held_data));
      held = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 64'({bus.out_result, bus.out_flags}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_word = exp_q.pop_front();
          chk("pop_data", 64'({bus.out_result, bus.out_flags}), 64'(exp_word));
        end
      end else if (bus.out_valid) begin
        held      = 1'b1;
        held_data = {bus.out_result, bus.out_flags};
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] f, input logic r);
    bus.in_valid  = v;
    bus.in_result = d;
    {bus.in_v, bus.in_c, bus.in_n, bus.in_z} = f;
    bus.out_ready = r;
    cyc();
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && model_cnt != 0; i++) cyc();
    chk("drain_count", 64'(bus.count), 64'd0);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int idx;
    logic v;
    logic [31:0] d;
    total = 0;
    bad   = 0;
    held  = 1'b0;
    model_cnt = 0;
    model_sv  = 1'b0;
    model_sc  = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_result = '0;
    {bus.in_v, bus.in_c, bus.in_n, bus.in_z} = 4'b0;
    bus.out_ready = 1'b0;
    bus.sticky_clr = 1'b0;

    cyc();
    rst = 1'b0;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_sticky", 64'({bus.sticky_v, bus.sticky_c}), 64'd0);
    cyc();

    // Fill to full, refused fifth beat, then drain in order.
    drive(1'b1, 32'h1, 4'b0001, 1'b0);
    drive(1'b1, 32'h2, 4'b0010, 1'b0);
    drive(1'b1, 32'h3, 4'b0100, 1'b0);
    drive(1'b1, 32'h4, 4'b1000, 1'b0);
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'hDEADBEEF, 4'b1111, 1'b0);
    chk("full_ignored", 64'(bus.count), 64'd4);
    drain();

    // Simultaneous push and pop at count=2.
    drive(1'b1, 32'hB1, 4'b0011, 1'b0);
    drive(1'b1, 32'hB2, 4'b0110, 1'b0);
    chk("pp_before", 64'(bus.count), 64'd2);
    drive(1'b1, 32'hAAAA5555, 4'b1010, 1'b1);
    chk("pp_after", 64'(bus.count), 64'd2);
    chk("pp_head", 64'(bus.out_result), 64'h0000_00B2);
    drain();

    // Wrap-around with random consumer stalls.
    idx = 0;
    for (int c = 0; c < 300 && (idx < 10 || model_cnt != 0); c++) begin
      v = (idx < 10);
      d = 32'h10 + 32'(idx);
      if (v && model_cnt < DEPTH) begin
        drive(1'b1, d, 4'(idx), 1'($urandom_range(0, 1)));
        idx++;
      end else begin
        drive(v, d, 4'(idx), 1'($urandom_range(0, 1)));
      end
    end
    chk("wrap_pushed", 64'(idx), 64'd10);
    drain();

    // Reset mid-operation discards contents.
    drive(1'b1, 32'hC1, 4'b0001, 1'b0);
    drive(1'b1, 32'hC2, 4'b0001, 1'b0);
    drive(1'b1, 32'hC3, 4'b0001, 1'b0);
    chk("mid_count", 64'(bus.count), 64'd3);
    rst = 1'b1;
    drive(1'b1, 32'hBAD0BAD0, 4'b1111, 1'b1);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 32'h12345678, 4'b0101, 1'b0);
    chk("mid_first", 64'(bus.out_result), 64'h1234_5678);
    drain();

`ifdef ULA_STICKY_FLAGS_EN
    drive(1'b1, 32'h50, 4'b1000, 1'b1);
    drive(1'b1, 32'h51, 4'b0000, 1'b1);
    drive(1'b1, 32'h52, 4'b0000, 1'b1);
    drive(1'b1, 32'h53, 4'b0000, 1'b1);
    chk("sticky_v_held", 64'(bus.sticky_v), 64'd1);
    bus.sticky_clr = 1'b1;
    drive(1'b1, 32'h54, 4'b0100, 1'b1);
    bus.sticky_clr = 1'b0;
    chk("sticky_clr_v", 64'(bus.sticky_v), 64'd0);
    chk("sticky_clr_c", 64'(bus.sticky_c), 64'd1);
    drain();
`endif

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      bus.sticky_clr = ($urandom_range(0, 7) == 0);
      drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 2) != 0));
    end
    bus.sticky_clr = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ula_result_fifo.md
Name: ula_result_fifo

Overview:
Downstream stage of the 32-bit ULA. Captures each ULA result word together with its v/c/n/z flags into a small FIFO, so the consumer (register file writeback or bus interface) can apply backpressure without stalling the ULA. It uses a valid/ready handshake on both sides, and an optional sticky-flag accumulator.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  ULA presents a result this cycle.
in_ready  output  1  FIFO can accept; equals (count < DEPTH).
in_result  input  32  ULA result word.
in_v  input  1  overflow flag.
in_c  input  1  carry flag.
in_n  input  1  negative flag.
in_z  input  1  zero flag.
out_valid  output  1  head entry available; equals (count != 0).
out_ready  input  1  consumer accepts head.
out_result  output  32  head result word.
out_flags  output  4  head flags, packed {v,c,n,z}.
count  output  AW+1  current occupancy, 0..DEPTH.
sticky_clr  input  1  clears sticky flags (feature only; ignored otherwise).
sticky_v  output  1  OR of all accepted v since last clear (feature only; else 0).
sticky_c  output  1  OR of all accepted c since last clear (feature only; else 0).

Behaviour:
- Reset: one clk cycle with rst=1 is sufficient. It sets wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, sticky_v=0, sticky_c=0. Storage contents are don't-care.
- Reset mid-operation discards all entries; rst has priority over every other input.
- Push: the beat is accepted when in_valid && in_ready at posedge. The entry {in_result, in_v, in_c, in_n, in_z} is written at wr_ptr, then wr_ptr increments modulo DEPTH.
- Pop: the beat is accepted when out_valid && out_ready at posedge. Then rd_ptr increments modulo DEPTH.
- Output path:
  - out_result and out_flags are driven combinationally from the entry at rd_ptr.
  - They are valid only while out_valid=1 and must hold stable while out_valid=1 && out_ready=0.
- Latency: an entry pushed at edge k is visible with out_valid=1 in the cycle after edge k. There is no same-cycle pass-through when empty.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, and both pointers advance.
- Full (count=DEPTH): in_ready=0 and in_valid is ignored. A pop in the same cycle does NOT enable a push; in_ready is not a function of out_ready.
- Empty (count=0): out_valid=0 and out_ready is ignored. A push in the same cycle is accepted normally.
- Pointer wrap: pointers are AW bits and wrap from DEPTH-1 to 0. Occupancy comes solely from the count register.
- Data is never lost or duplicated. Order is strictly FIFO.

Optional Feature:
ULA_STICKY_FLAGS_EN
- Defined:
  - On each accepted push: sticky_v <= sticky_v | in_v, and sticky_c <= sticky_c | in_c.
  - sticky_clr=1 loads sticky_v/sticky_c with the pushed flags if a push is accepted that same cycle, else 0.
  - rst clears both.
- Undefined:
  - sticky_v and sticky_c are tied to 0.
  - sticky_clr is unused.
  - No sticky registers are synthesised.

Test Plan:
- Reset then idle: rst=1 for 1 cycle -> count=0, out_valid=0, in_ready=1, sticky_v=sticky_c=0.
- Fill and drain: out_ready=0, push 0x00000001..0x00000004 with flags 4'b0001,0010,0100,1000.
  - After 4 pushes: count=4, in_ready=0.
  - A 5th push of 0xDEADBEEF is ignored.
  - Then out_ready=1 -> 0x1,0x2,0x3,0x4 appear in order with matching flags; count ends at 0.
- Simultaneous push/pop at count=2: push 0xAAAA5555 while popping -> count stays 2, head advances, 0xAAAA5555 emerges two pops later.
- Wrap-around: 10 push/pop pairs of 0x10..0x19 with random out_ready stalls -> output sequence 0x10..0x19 exact, and out_result stable during every stall.
- Reset mid-operation: count=3, assert rst -> next cycle count=0, out_valid=0; subsequent push of 0x12345678 is the first output.
- With ULA_STICKY_FLAGS_EN:
  - Push v=1 then three v=0 beats -> sticky_v=1.
  - sticky_clr with a simultaneous push c=1,v=0 -> sticky_v=0, sticky_c=1.
